intt_gs: RTL and testbench

//  Inverse NTT engine: the counterpart of the forward radix-2 ntt core.
//  - Runs in place on the same single-port coefficient BRAM, using Gentleman-Sande (GS) butterflies.
//  - Input is in bit-reversed order, as the forward core leaves it; output is in natural order.
//  - Inverse twiddles come from a separate 1-cycle-latency ROM. Addresses are generated internally (no address ROM).

---
 rtl/ntt_pkg.sv | 27 ++
 rtl/intt_butterfly.sv | 38 +++
 rtl/intt_gs.sv | 146 ++++++++++++++
 tb/tb_intt_gs.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants, FSM encoding and modular add/sub helpers for the inverse NTT engine.
// The optional scaling pass is enabled by defining INTT_NINV_SCALE_EN.
package ntt_pkg;
    localparam int N    = 256;
    localparam int LOGN = 8;
    localparam int DW   = 32;
    localparam int STW  = $clog2(LOGN);
    localparam logic [DW-1:0] Q     = 32'd7681;
    localparam logic [DW-1:0] N_INV = 32'd7651;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_A, S_RD_B, S_CAP, S_BFLY, S_WR_A, S_WR_B, S_DONE,
        S_SC_RD, S_SC_CAP, S_SC_MUL, S_SC_WR
    } state_t;

    function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, Q}) s = s - {1'b0, Q};
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (a >= b) return a - b;
        return a + (Q - b);
    endfunction
endpackage

// File: rtl/intt_butterfly.sv
// Gentleman-Sande butterfly: a' = a+b, b' = (a-b)*w mod Q, results registered.
// With scale set the difference stage is bypassed so b' = a*w (used by INTT_NINV_SCALE_EN pass).
module intt_butterfly
    import ntt_pkg::*;
(
    input  logic          clk,
    input  logic          en,
    input  logic          scale,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] w,
    output logic [DW-1:0] sum,
    output logic [DW-1:0] prod
);
    function automatic logic [DW-1:0] mod_mul(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [2*DW-1:0] p;
        logic [DW-1:0]   r;
        p = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
        r = DW'(p % {{DW{1'b0}}, Q});
        return r;
    endfunction

    logic [DW-1:0] diff;
    logic [DW-1:0] sum_c;
    logic [DW-1:0] prod_c;

    assign diff   = scale ? a : mod_sub(a, b);
    assign sum_c  = mod_add(a, b);
    assign prod_c = mod_mul(diff, w);

    // stage boundary: butterfly results
    always_ff @(posedge clk) begin
        if (en) begin
            sum  <= sum_c;
            prod <= prod_c;
        end
    end
endmodule

// File: rtl/intt_gs.sv
// In-place inverse NTT (GS butterflies, bit-reversed in, natural order out) over a single-port BRAM.
// Define INTT_NINV_SCALE_EN to append an N^-1 scaling pass giving the true inverse.
module intt_gs
    import ntt_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [LOGN-1:0] coeff_addr,
    output logic            coeff_we,
    output logic [DW-1:0]   coeff_din,
    input  logic [DW-1:0]   coeff_dout,
    output logic [LOGN-1:0] twid_rom_addr,
    input  logic [DW-1:0]   twid_rom_data
);
    state_t          state, state_nx;
    logic [STW-1:0]  stage;
    logic [LOGN-1:0] st, k;
    logic [LOGN-1:0] len, a_addr, b_addr, twid;
    logic [LOGN:0]   st_next;
    logic            last_k, last_stage, done_all;
    logic [DW-1:0]   a_p0, b_p0, w_p0;
    logic [DW-1:0]   a_p1, b_p1;
`ifdef INTT_NINV_SCALE_EN
    logic [LOGN-1:0] sc_idx;
`endif

    assign len        = LOGN'(1) << stage;
    assign a_addr     = st + k;
    assign b_addr     = a_addr + len;
    assign st_next    = {1'b0, st} + {len, 1'b0};
    assign last_k     = (k == len - 1'b1);
    assign last_stage = (stage == STW'(LOGN - 1));
    assign done_all   = last_k && st_next[LOGN] && last_stage;
    // (N >> (s+1)) + (st >> (s+1)), kept within LOGN bits
    assign twid       = (LOGN'(N / 2) >> stage) + ((st >> 1) >> stage);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            stage <= '0;
            st    <= '0;
            k     <= '0;
`ifdef INTT_NINV_SCALE_EN
            sc_idx <= '0;
`endif
        end else begin
            state <= state_nx;
            if (state == S_WR_B) begin
                if (last_k) begin
                    k  <= '0;
                    st <= st_next[LOGN-1:0];
                    if (st_next[LOGN]) stage <= last_stage ? '0 : stage + 1'b1;
                end else begin
                    k <= k + 1'b1;
                end
            end
`ifdef INTT_NINV_SCALE_EN
            if (state == S_SC_WR) sc_idx <= sc_idx + 1'b1;
`endif
        end
    end

    // stage boundary: operand capture from BRAM / ROM read ports
    always_ff @(posedge clk) begin
        if (state == S_RD_B) a_p0 <= coeff_dout;
        if (state == S_CAP) begin
            b_p0 <= coeff_dout;
            w_p0 <= twid_rom_data;
        end
`ifdef INTT_NINV_SCALE_EN
        if (state == S_SC_CAP) a_p0 <= coeff_dout;
`endif
    end

    intt_butterfly u_bfly (
        .clk   (clk),
        .en    ((state == S_BFLY) || (state == S_SC_MUL)),
        .scale (state == S_SC_MUL),
        .a     (a_p0),
        .b     (b_p0),
        .w     ((state == S_SC_MUL) ? N_INV : w_p0),
        .sum   (a_p1),
        .prod  (b_p1)
    );

    always_comb begin
        state_nx      = state;
        busy          = 1'b0;
        done          = 1'b0;
        coeff_addr    = '0;
        coeff_we      = 1'b0;
        coeff_din     = '0;
        twid_rom_addr = '0;
        case (state)
            S_IDLE: if (start) state_nx = S_RD_A;
            S_RD_A: begin
                busy = 1'b1; coeff_addr = a_addr; twid_rom_addr = twid; state_nx = S_RD_B;
            end
            S_RD_B: begin
                busy = 1'b1; coeff_addr = b_addr; twid_rom_addr = twid; state_nx = S_CAP;
            end
            S_CAP: begin
                busy = 1'b1; twid_rom_addr = twid; state_nx = S_BFLY;
            end
            S_BFLY: begin
                busy = 1'b1; twid_rom_addr = twid; state_nx = S_WR_A;
            end
            S_WR_A: begin
                busy = 1'b1; coeff_we = 1'b1; coeff_addr = a_addr; coeff_din = a_p1;
                twid_rom_addr = twid; state_nx = S_WR_B;
            end
            S_WR_B: begin
                busy = 1'b1; coeff_we = 1'b1; coeff_addr = b_addr; coeff_din = b_p1;
                twid_rom_addr = twid;
`ifdef INTT_NINV_SCALE_EN
                state_nx = done_all ? S_SC_RD : S_RD_A;
`else
                state_nx = done_all ? S_DONE : S_RD_A;
`endif
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nx = S_RD_A;
            end
`ifdef INTT_NINV_SCALE_EN
            S_SC_RD: begin
                busy = 1'b1; coeff_addr = sc_idx; state_nx = S_SC_CAP;
            end
            S_SC_CAP: begin
                busy = 1'b1; coeff_addr = sc_idx; state_nx = S_SC_MUL;
            end
            S_SC_MUL: begin
                busy = 1'b1; coeff_addr = sc_idx; state_nx = S_SC_WR;
            end
            S_SC_WR: begin
                busy = 1'b1; coeff_we = 1'b1; coeff_addr = sc_idx; coeff_din = b_p1;
                state_nx = (sc_idx == LOGN'(N - 1)) ? S_DONE : S_SC_RD;
            end
`endif
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_intt_gs.sv
// Scoreboard bench for intt_gs: forward negacyclic NTT model builds inputs, expected results queued.
// Honours INTT_NINV_SCALE_EN for expected values and latency.
module tb_intt_gs;
    import ntt_pkg::*;

    localparam longint QL = 7681;
`ifdef INTT_NINV_SCALE_EN
    localparam int SCALED = 1;
`else
    localparam int SCALED = 0;
`endif
    localparam int LAT = 1 + 6 * (N / 2) * LOGN + SCALED * 4 * N;

    logic            clk = 1'b0;
    logic            rst, start;
    logic            busy, done, coeff_we;
    logic [LOGN-1:0] coeff_addr, twid_rom_addr;
    logic [DW-1:0]   coeff_din, coeff_dout, twid_rom_data;

    intt_gs dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .coeff_addr    (coeff_addr),
        .coeff_we      (coeff_we),
        .coeff_din     (coeff_din),
        .coeff_dout    (coeff_dout),
        .twid_rom_addr (twid_rom_addr),
        .twid_rom_data (twid_rom_data)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] init_mem [N];
    logic [DW-1:0] rom [N];
    bit            load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < N; i++) mem[i] <= init_mem[i];
        end else if (coeff_we) begin
            mem[coeff_addr] <= coeff_din;
        end
        coeff_dout    <= mem[coeff_addr];
        twid_rom_data <= rom[twid_rom_addr];
    end

    bit     trace_en = 1'b0;
    longint wa_q[$];
    longint tw_q[$];
    always @(negedge clk) begin
        if (trace_en && coeff_we) begin
            wa_q.push_back(longint'(coeff_addr));
            tw_q.push_back(longint'(twid_rom_addr));
        end
    end

    int     total = 0;
    int     bad = 0;
    longint exp_q[$];
    longint poly[N];
    longint fwd[N];
    longint zetas[N];

    task automatic check(input string tag, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic longint modpow(input longint b, input longint e);
        longint r = 1;
        b = b % QL;
        while (e > 0) begin
            if (e[0]) r = (r * b) % QL;
            b = (b * b) % QL;
            e = e >> 1;
        end
        return r;
    endfunction

    function automatic int brv(input int x);
        int r = 0;
        for (int i = 0; i < LOGN; i++) r = (r << 1) | ((x >> i) & 1);
        return r;
    endfunction

    // Forward Cooley-Tukey negacyclic NTT: natural order in, bit-reversed out
    task automatic ntt_fwd();
        int kk = 1;
        longint z, t;
        for (int i = 0; i < N; i++) fwd[i] = poly[i];
        for (int ln = N / 2; ln >= 1; ln = ln / 2) begin
            for (int s0 = 0; s0 < N; s0 += 2 * ln) begin
                z = zetas[kk];
                kk++;
                for (int j = s0; j < s0 + ln; j++) begin
                    t = (z * fwd[j + ln]) % QL;
                    fwd[j + ln] = (fwd[j] + QL - t) % QL;
                    fwd[j] = (fwd[j] + t) % QL;
                end
            end
        end
    endtask

    task automatic load_bram();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic run_case(input string tag, input bit pulse_mid);
        int n = 0;
        bit seen = 1'b0;
        for (int i = 0; i < N; i++)
            exp_q.push_back(SCALED != 0 ? poly[i] : (poly[i] * N) % QL);
        load_bram();
        @(negedge clk);
        start = 1'b1;
        while (!seen && n < LAT + 200) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                start = 1'b0;
                check($sformatf("%s:busy_on", tag), longint'(busy), 1);
                check($sformatf("%s:done_clr", tag), longint'(done), 0);
                check($sformatf("%s:rd_a_addr", tag), longint'(coeff_addr), 0);
                check($sformatf("%s:first_twid", tag), longint'(twid_rom_addr), 128);
            end
            if (n == 2) check($sformatf("%s:rd_b_addr", tag), longint'(coeff_addr), 1);
            if (pulse_mid && n == 100) start = 1'b1;
            if (pulse_mid && n == 101) start = 1'b0;
            if (done) seen = 1'b1;
        end
        check($sformatf("%s:latency", tag), longint'(n), longint'(LAT));
        check($sformatf("%s:busy_off", tag), longint'(busy), 0);
        for (int i = 0; i < N; i++)
            check($sformatf("%s:coeff[%0d]", tag, i), longint'(mem[i]), exp_q.pop_front());
    endtask

    initial begin
        longint psi = 0;
        int base;
        rst   = 1'b1;
        start = 1'b0;
        for (longint g = 2; g < QL && psi == 0; g++)
            if (modpow(g, N) == QL - 1) psi = g;
        for (int i = 0; i < N; i++) begin
            zetas[i] = modpow(psi, brv(i));
            rom[i]   = DW'(modpow(psi, 2 * N - brv(i)));
        end

        #2;
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_we", longint'(coeff_we), 0);
        check("rst_addr", longint'(coeff_addr), 0);
        check("rst_twid", longint'(twid_rom_addr), 0);
        check("rst_din", longint'(coeff_din), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < N; i++) begin
            poly[i] = 0;
            init_mem[i] = '0;
        end
        trace_en = 1'b1;
        run_case("zero", 1'b0);
        trace_en = 1'b0;
        check("trace_len", longint'(wa_q.size() >= 2 * (N / 2) * LOGN), 1);
        if (wa_q.size() >= 2 * (N / 2) * LOGN) begin
            check("trace_wr_a0", wa_q[0], 0);
            check("trace_wr_b0", wa_q[1], 1);
            check("trace_tw0", tw_q[0], 128);
            base = 2 * (N / 2) * (LOGN - 1);
            for (int j = 0; j < N / 2; j++) begin
                check($sformatf("last_a[%0d]", j), wa_q[base + 2 * j], j);
                check($sformatf("last_b[%0d]", j), wa_q[base + 2 * j + 1], j + N / 2);
                check($sformatf("last_tw[%0d]", j), tw_q[base + 2 * j], 1);
            end
        end

        for (int i = 0; i < N; i++) begin
            poly[i] = (i == 0) ? 1 : 0;
            init_mem[i] = DW'(1);
        end
        run_case("ones", 1'b0);

        for (int sd = 0; sd < 3; sd++) begin
            for (int i = 0; i < N; i++) poly[i] = longint'($urandom_range(0, 7680));
            ntt_fwd();
            for (int i = 0; i < N; i++) init_mem[i] = DW'(fwd[i]);
            run_case($sformatf("rand%0d", sd), sd == 0);
        end

        for (int i = 0; i < N; i++) poly[i] = longint'($urandom_range(0, 7680));
        ntt_fwd();
        for (int i = 0; i < N; i++) init_mem[i] = DW'(fwd[i]);
        load_bram();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2999) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", longint'(busy), 0);
        check("midrst_we", longint'(coeff_we), 0);
        check("midrst_done", longint'(done), 0);
        check("midrst_addr", longint'(coeff_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        run_case("after_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
